// File: rtl/glide_freq_table.sv
// glide_freq_table: registered multi-channel note-to-divider table with
// per-channel portamento and an LFSR-driven random voice on channel 0.
module glide_freq_table #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 18,
  parameter int GLIDE_SHIFT = 4,
  parameter int TICK_DIV    = 12000,
  parameter int GOOF_TICKS  = 125,
  parameter int MAX_OCT     = 4,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CH_W-1:0]           req_ch,
  input  logic [3:0]                req_key,
  input  logic [2:0]                req_octave,
  input  logic                      req_glide,
  input  logic                      goof_en,
  output logic [CHANNELS*DIV_W-1:0] divider,
  output logic [CHANNELS-1:0]       settled,
  output logic                      err
);

  localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GC_W = (GOOF_TICKS > 1) ? $clog2(GOOF_TICKS) : 1;
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(45868);

  function automatic logic [DIV_W-1:0] base_div(input logic [3:0] k);
    logic [DIV_W-1:0] r;
    unique case (k)
      4'd0:    r = DIV_W'(183458);
      4'd1:    r = DIV_W'(173160);
      4'd2:    r = DIV_W'(163443);
      4'd3:    r = DIV_W'(154281);
      4'd4:    r = DIV_W'(145613);
      4'd5:    r = DIV_W'(137441);
      4'd6:    r = DIV_W'(129730);
      4'd7:    r = DIV_W'(122449);
      4'd8:    r = DIV_W'(115574);
      4'd9:    r = DIV_W'(109091);
      4'd10:   r = DIV_W'(102969);
      4'd11:   r = DIV_W'(97190);
      4'd12:   r = DIV_W'(91736);
      default: r = '0;
    endcase
    return r;
  endfunction

  // note index 0..59 walks the table by octave; above that, shifted C
  function automatic logic [DIV_W-1:0] goof_div(input logic [5:0] n);
    logic [DIV_W-1:0] r;
    if (n < 6'd60) begin
      r = base_div(4'(n % 6'd12)) >> (n / 6'd12);
    end else begin
      r = base_div(4'd0) >> (n - 6'd59);
    end
    return r;
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [CH_W-1:0] s1_ch_q, s1_ch_d;
  logic [3:0]      s1_key_q, s1_key_d;
  logic [2:0]      s1_oct_q, s1_oct_d;
  logic            s1_gl_q, s1_gl_d;

  logic [TC_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [GC_W-1:0] goof_cnt_q, goof_cnt_d;
  logic [5:0]      lfsr_q, lfsr_d;

  logic [DIV_W-1:0] cur_q [CHANNELS];
  logic [DIV_W-1:0] cur_d [CHANNELS];
  logic [DIV_W-1:0] tgt_q [CHANNELS];
  logic [DIV_W-1:0] tgt_d [CHANNELS];
  logic [CHANNELS-1:0] gl_q, gl_d;

  logic [DIV_W-1:0] dlt [CHANNELS];
  logic [DIV_W-1:0] stp [CHANNELS];

  logic             accept;
  logic             tick;
  logic             goof_fire;
  logic [DIV_W-1:0] goof_note;
  logic             s1_bad;
  logic             s1_ign;
  logic             wr_en;
  logic [2:0]       oct_eff;
  logic [DIV_W-1:0] wr_div;

  assign req_ready = !s1_valid_q;
  assign accept    = req_valid && req_ready;
  assign tick      = (tick_cnt_q == TC_W'(TICK_DIV - 1));

  assign s1_bad  = (s1_key_q > 4'd12) || (int'(s1_ch_q) >= CHANNELS);
  assign s1_ign  = goof_en && (s1_ch_q == '0);
  assign err     = s1_valid_q && s1_bad;
  assign wr_en   = s1_valid_q && !s1_bad && !s1_ign;
  assign oct_eff = (s1_oct_q > 3'(MAX_OCT)) ? 3'(MAX_OCT) : s1_oct_q;
  assign wr_div  = base_div(s1_key_q) >> oct_eff;

  // capture an accepted request; stage 1 holds it for exactly one cycle
  always_comb begin
    s1_valid_d = accept;
    s1_ch_d    = s1_ch_q;
    s1_key_d   = s1_key_q;
    s1_oct_d   = s1_oct_q;
    s1_gl_d    = s1_gl_q;
    if (accept) begin
      s1_ch_d  = req_ch;
      s1_key_d = req_key;
      s1_oct_d = req_octave;
      s1_gl_d  = req_glide;
    end
  end

  // glide tick divider, goof tick counter and LFSR advance
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TC_W'(1);
    goof_cnt_d = goof_cnt_q;
    lfsr_d     = lfsr_q;
    goof_fire  = 1'b0;
    if (!goof_en) begin
      goof_cnt_d = '0;
    end else if (tick) begin
      if (goof_cnt_q == GC_W'(GOOF_TICKS - 1)) begin
        goof_cnt_d = '0;
        lfsr_d     = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        goof_fire  = 1'b1;
      end else begin
        goof_cnt_d = goof_cnt_q + GC_W'(1);
      end
    end
  end

  assign goof_note = goof_div(lfsr_d);

  // per-channel slew step: |target-current| >> shift, at least 1
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (cur_q[i] > tgt_q[i]) begin
        dlt[i] = cur_q[i] - tgt_q[i];
      end else begin
        dlt[i] = tgt_q[i] - cur_q[i];
      end
      stp[i] = dlt[i] >> GLIDE_SHIFT;
      if (stp[i] == '0) begin
        stp[i] = DIV_W'(1);
      end
    end
  end

  // channel update: glide step, then goof jump, then request write win
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cur_d[i] = cur_q[i];
      tgt_d[i] = tgt_q[i];
      gl_d[i]  = gl_q[i];
      if (tick && gl_q[i] && (cur_q[i] != tgt_q[i])) begin
        if (cur_q[i] > tgt_q[i]) begin
          cur_d[i] = cur_q[i] - stp[i];
        end else begin
          cur_d[i] = cur_q[i] + stp[i];
        end
      end
      if (goof_fire && (i == 0)) begin
        cur_d[i] = goof_note;
        tgt_d[i] = goof_note;
        gl_d[i]  = 1'b0;
      end
      if (wr_en && (s1_ch_q == CH_W'(i))) begin
        tgt_d[i] = wr_div;
        gl_d[i]  = s1_gl_q;
        if (!s1_gl_q) begin
          cur_d[i] = wr_div;
        end
      end
    end
  end

  // control registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_key_q   <= '0;
      s1_oct_q   <= '0;
      s1_gl_q    <= 1'b0;
      tick_cnt_q <= '0;
      goof_cnt_q <= '0;
      lfsr_q     <= 6'b000001;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_key_q   <= s1_key_d;
      s1_oct_q   <= s1_oct_d;
      s1_gl_q    <= s1_gl_d;
      tick_cnt_q <= tick_cnt_d;
      goof_cnt_q <= goof_cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // channel state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gl_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_q[i] <= RST_DIV;
        tgt_q[i] <= RST_DIV;
      end
    end else begin
      gl_q <= gl_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_q[i] <= cur_d[i];
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign divider[g*DIV_W +: DIV_W] = cur_q[g];
    assign settled[g] = (cur_q[g] == tgt_q[g]);
  end

endmodule

// File: tb/tb_glide_freq_table.sv
// tb_glide_freq_table: directed literal checks plus randomized traffic
// compared every cycle against a plain-arithmetic channel model.
`timescale 1ns/1ps
module tb_glide_freq_table;

  localparam int NCH = 3;
  localparam int DW  = 18;
  localparam int GS  = 4;
  localparam int TD  = 16;
  localparam int GT  = 125;
  localparam int MO  = 4;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_glide = 1'b0;
  logic goof_en = 1'b0;
  logic [CW-1:0] req_ch = '0;
  logic [3:0] req_key = '0;
  logic [2:0] req_octave = '0;
  logic req_ready;
  logic err;
  logic [NCH*DW-1:0] divider;
  logic [NCH-1:0] settled;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  glide_freq_table #(
    .CHANNELS(NCH), .DIV_W(DW), .GLIDE_SHIFT(GS),
    .TICK_DIV(TD), .GOOF_TICKS(GT), .MAX_OCT(MO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_key(req_key),
    .req_octave(req_octave), .req_glide(req_glide),
    .goof_en(goof_en), .divider(divider),
    .settled(settled), .err(err)
  );

  int BASE [13] = '{183458, 173160, 163443, 154281, 145613,
                    137441, 129730, 122449, 115574, 109091,
                    102969, 97190, 91736};

  int m_cur [NCH];
  int m_tgt [NCH];
  bit m_gl  [NCH];
  int m_tc, m_gc, m_lfsr;
  bit p_v, p_gl;
  int p_ch, p_key, p_oct;

  function automatic int dut_div(input int ch);
    return int'(divider[ch*DW +: DW]);
  endfunction

  function automatic bit bad(input int ch, input int key);
    return (key > 12) || (ch >= NCH);
  endfunction

  function automatic int goof_div(input int n);
    if (n < 60) return BASE[n % 12] >> (n / 12);
    return BASE[0] >> (n - 59);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = 45868;
      m_tgt[i] = 45868;
      m_gl[i] = 1'b0;
    end
    m_tc = 0;
    m_gc = 0;
    m_lfsr = 1;
    p_v = 1'b0;
  endfunction

  function automatic void model_step();
    bit tick;
    int d, s, t;
    tick = (m_tc == TD - 1);
    if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (m_gl[i] && m_cur[i] != m_tgt[i]) begin
          d = m_tgt[i] - m_cur[i];
          if (d < 0) d = -d;
          s = d / (1 << GS);
          if (s == 0) s = 1;
          m_cur[i] += (m_tgt[i] > m_cur[i]) ? s : -s;
        end
      end
    end
    if (!goof_en) begin
      m_gc = 0;
    end else if (tick) begin
      m_gc++;
      if (m_gc == GT) begin
        m_gc = 0;
        m_lfsr = ((m_lfsr * 2) % 64) + (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
        t = goof_div(m_lfsr);
        m_cur[0] = t;
        m_tgt[0] = t;
        m_gl[0] = 1'b0;
      end
    end
    if (p_v && !bad(p_ch, p_key) && !(goof_en && p_ch == 0)) begin
      t = BASE[p_key] >> ((p_oct > MO) ? MO : p_oct);
      m_tgt[p_ch] = t;
      m_gl[p_ch] = p_gl;
      if (!p_gl) m_cur[p_ch] = t;
    end
    if (!p_v && req_valid) begin
      p_v = 1'b1;
      p_ch = int'(req_ch);
      p_key = int'(req_key);
      p_oct = int'(req_octave);
      p_gl = req_glide;
    end else begin
      p_v = 1'b0;
    end
    m_tc = (m_tc + 1) % TD;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (n_rst) begin
      int se;
      se = 0;
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("model_div%0d", i), dut_div(i), m_cur[i]);
        if (m_cur[i] == m_tgt[i]) se |= (1 << i);
      end
      chk("model_settled", int'(settled), se);
      chk("model_ready", int'(req_ready), int'(!p_v));
      chk("model_err", int'(err), int'(p_v && bad(p_ch, p_key)));
    end
  end

  task automatic send(input int ch, input int key, input int oct,
                      input bit gl, input bit at_tick);
    @(posedge clk); #1;
    if (at_tick) begin
      for (int k = 0; k < TD + 2 && m_tc != TD - 2; k++) begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b1;
    req_ch = CW'(ch);
    req_key = 4'(key);
    req_octave = 3'(oct);
    req_glide = gl;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic req_chk(input int ch, input int key, input int oct,
                         input bit gl, input bit at_tick, input int exp_err,
                         input int cch, input int exp_div, input string nm);
    send(ch, key, oct, gl, at_tick);
    @(negedge clk);
    chk({nm, "_ready_a1"}, int'(req_ready), 0);
    chk({nm, "_err_a1"}, int'(err), exp_err);
    @(negedge clk);
    chk({nm, "_err_a2"}, int'(err), 0);
    chk({nm, "_div_a2"}, dut_div(cch), exp_div);
  endtask

  task automatic wait_change(input int ch, input int from, input int exp,
                             input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < TD + 4 && !ok; k++) begin
      @(negedge clk);
      if (dut_div(ch) != from) ok = 1'b1;
    end
    chk({nm, "_seen"}, int'(ok), 1);
    chk(nm, dut_div(ch), exp);
  endtask

  task automatic wait_settle(input int ch, input int lo, input int hi,
                             input bit up, input string nm);
    int prev, cur, viol;
    bit done;
    viol = 0;
    done = 1'b0;
    prev = dut_div(ch);
    for (int k = 0; k < 400 * TD && !done; k++) begin
      @(negedge clk);
      cur = dut_div(ch);
      if (up ? (cur < prev) : (cur > prev)) viol++;
      if (cur < lo || cur > hi) viol++;
      prev = cur;
      done = settled[ch];
    end
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_monotonic"}, viol, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    n_rst = 1'b0;
    @(negedge clk); #2;
    n_rst = 1'b1;
  endtask

  initial begin
    // reset with goof mode already on
    goof_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    n_rst = 1'b1;
    #1;
    for (int i = 0; i < NCH; i++)
      chk($sformatf("rst_div%0d", i), dut_div(i), 45868);
    chk("rst_settled", int'(settled), 7);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_err", int'(err), 0);

    // first goof note lands on the GT-th tick edge
    repeat (GT * TD - 1) @(posedge clk);
    @(negedge clk);
    chk("goof_before", dut_div(0), 45868);
    @(posedge clk);
    @(negedge clk);
    chk("goof_note", dut_div(0), 163443);
    chk("goof_settled0", int'(settled[0]), 1);
    req_chk(0, 5, 0, 1'b0, 1'b0, 0, 0, 163443, "goof_ignore");
    req_chk(1, 9, 2, 1'b0, 1'b0, 0, 1, 27272, "jump");
    chk("jump_settled1", int'(settled[1]), 1);

    // glide up, then retarget down and back up
    goof_en = 1'b0;
    pulse_reset();
    req_chk(0, 0, 0, 1'b1, 1'b0, 0, 0, 45868, "glide_start");
    chk("glide_unsettled", int'(settled[0]), 0);
    wait_change(0, 45868, 54467, "glide_tick1");
    chk("glide_tick1_settled", int'(settled[0]), 0);
    wait_settle(0, 45868, 183458, 1'b1, "glide_up");
    chk("glide_final", dut_div(0), 183458);
    req_chk(0, 0, 4, 1'b1, 1'b0, 0, 0, 183458, "retarget_dn");
    wait_change(0, 183458, 172709, "dn_tick1");
    wait_change(0, 172709, 162632, "dn_tick2");
    req_chk(0, 0, 0, 1'b1, 1'b0, 0, 0, 162632, "retarget_up");
    wait_change(0, 162632, 163933, "up_tick1");
    wait_settle(0, 162632, 183458, 1'b1, "reglide_up");
    chk("reglide_final", dut_div(0), 183458);

    // invalid requests and octave clamp
    req_chk(1, 13, 0, 1'b0, 1'b0, 1, 1, 45868, "bad_key");
    chk("bad_key_ch0", dut_div(0), 183458);
    req_chk(3, 0, 0, 1'b0, 1'b0, 1, 1, 45868, "bad_ch");
    req_chk(2, 0, 7, 1'b0, 1'b0, 0, 2, 11466, "clamp");

    // collisions on the tick cycle
    req_chk(1, 0, 0, 1'b0, 1'b0, 0, 1, 183458, "col_setup");
    req_chk(1, 0, 4, 1'b1, 1'b0, 0, 1, 183458, "col_glide");
    wait_change(1, 183458, 172709, "col_tick1");
    req_chk(1, 0, 0, 1'b1, 1'b1, 0, 1, 162632, "col_retarget");
    chk("col_unsettled", int'(settled[1]), 0);
    wait_change(1, 162632, 163933, "col_after");
    req_chk(1, 9, 2, 1'b0, 1'b1, 0, 1, 27272, "col_jump");
    chk("col_jump_settled", int'(settled[1]), 1);

    // asynchronous reset in the middle of a glide
    req_chk(1, 0, 4, 1'b1, 1'b0, 0, 1, 27272, "arst_glide");
    wait_change(1, 27272, 26285, "arst_tick1");
    @(negedge clk); #2;
    n_rst = 1'b0;
    #1;
    for (int i = 0; i < NCH; i++)
      chk($sformatf("arst_div%0d", i), dut_div(i), 45868);
    chk("arst_settled", int'(settled), 7);
    chk("arst_ready", int'(req_ready), 1);
    @(negedge clk); #2;
    n_rst = 1'b1;

    // randomized traffic, checked every cycle against the model
    goof_en = 1'b1;
    for (int k = 0; k < 4500; k++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) == 0);
      req_ch = CW'($urandom_range(0, 3));
      req_key = 4'($urandom_range(0, 15));
      req_octave = 3'($urandom_range(0, 7));
      req_glide = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) goof_en = ~goof_en;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glide_freq_table.md
Name: glide_freq_table

Overview:
- Multi-channel, registered successor to the combinational note-to-divider lookup.
- Accepts note requests (channel, key, octave, glide flag) over a valid/ready handshake and holds a per-channel target divider. Each channel's current divider either jumps to the target or slews to it (portamento) on a periodic glide tick.
- A goof mode drives channel 0 with pseudo-random notes from an internal LFSR.
- Sits between the keypad/mode logic and the per-voice oscillators. Dividers are in 12 MHz clock counts.

Parameters:
CHANNELS, 2, number of independent voices (1..8)
DIV_W, 18, divider width in bits
GLIDE_SHIFT, 4, glide step = |target - current| >> GLIDE_SHIFT, minimum 1
TICK_DIV, 12000, clocks per glide tick (1 kHz at 12 MHz)
GOOF_TICKS, 125, glide ticks between random notes in goof mode
MAX_OCT, 4, largest octave shift; larger requests clamp to this

Ports:
clk  in  1  system clock, 12 MHz
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  note request present
req_ready  out  1  block can accept a request this cycle
req_ch  in  max(1,$clog2(CHANNELS))  target channel
req_key  in  4  0..11 = C..B of base octave, 12 = C3; 13..15 invalid
req_octave  in  3  right-shift applied to the base divider
req_glide  in  1  1 = slew to the new target, 0 = jump
goof_en  in  1  enable random notes on channel 0
divider  out  CHANNELS*DIV_W  packed current dividers; channel i at [i*DIV_W +: DIV_W]
settled  out  CHANNELS  1 when the channel's current divider equals its target
err  out  1  one-cycle pulse when an accepted request is invalid

Behaviour:
- Reset (async, n_rst=0):
  - every current and target divider = 45868 (C3>>1); glide mode per channel = jump.
  - settled = all 1; err = 0; req_ready = 1; tick counter = 0; goof counter = 0; LFSR = 6'b000001.
- Base table (DIV_W bits): 183458, 173160, 163443, 154281, 145613, 137441, 129730, 122449, 115574, 109091, 102969, 97190, 91736 (key 0..12).
- Handshake and pipeline:
  - Accept when req_valid && req_ready; inputs are captured in stage 1.
  - req_ready = 0 in the cycle after an accept, otherwise 1. At most one request is in flight.
  - Stage 2 (accept cycle + 1): compute target = BASE[key] >> min(octave, MAX_OCT), then write the channel's target and glide flag.
  - Jump mode: current divider = target at accept + 2. settled reflects this the same cycle.
- Invalid request:
  - key 13..15, or req_ch >= CHANNELS: err pulses at accept + 1; no channel state changes.
- Glide tick: counter runs 0..TICK_DIV-1 and pulses at TICK_DIV-1. On each tick, for every channel in glide mode with current != target:
  - delta = |target - current|
  - step = delta >> GLIDE_SHIFT, forced to 1 if 0
  - current moves toward target by step and never overshoots.
- Retarget mid-glide: the slew continues from the present current value toward the new target. No reset of current.
- Same-cycle collision on one channel:
  - A request write beats a goof write.
  - A tick step in that cycle uses the old target.
  - A jump update beats a glide step.
- Goof mode (goof_en=1), driven on glide ticks:
  - Every GOOF_TICKS ticks, the LFSR advances: lfsr = {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - Channel 0 then jumps to a note index n = lfsr:
    - n < 60: BASE[n%12] >> (n/12)
    - n >= 60: 183458 >> (n-59)
  - Host requests to channel 0 are accepted but ignored: no err, no change.
  - Deasserting goof_en holds channel 0 at its last value and clears the goof counter.
- All arithmetic is unsigned DIV_W bits. Shifts are logical; zero-fill from the left.

Test Plan:
- Reset: hold n_rst=0, release -> every divider = 45868, settled all 1, req_ready=1, err=0. Assert n_rst mid-glide -> divider returns to 45868 immediately (async).
- Jump: ch1, key 9, octave 2, glide 0 -> divider[1] = 27272 at accept+2; req_ready=0 at accept+1; settled[1]=1.
- Glide: ch0 from 45868, key 0, octave 0, glide 1:
  - first tick -> 54467 (step 8599), settled[0]=0.
  - continues monotonically to exactly 183458, with no overshoot, then settled[0]=1.
  - a retarget mid-slew reverses direction from the current value.
- Invalid and clamp:
  - key 13 -> err pulse at accept+1, dividers unchanged.
  - key 0, octave 7 -> target 11466 (clamped to shift 4).
  - req_ch=2 with CHANNELS=2 -> err pulse.
- Goof: goof_en=1 from reset, after GOOF_TICKS ticks -> LFSR = 6'b000010, divider[0] = 163443. A host request to ch0 is ignored; a request to ch1 still works.
- Collision: a request to ch1 landing on the tick cycle while ch1 is gliding -> the new target is written and that tick's step uses the old target; a jump request lands exactly at accept+2.
